// File: rtl/ntt_stream_engine.sv
// Iterative N-point modular NTT/INTT engine: streams in coefficients and twiddles,
// runs one butterfly per cycle in place, then streams results out in natural order.
module ntt_stream_engine #(
  parameter int WIDTH = 18,
  parameter int LOG_N = 3,
  parameter int Q     = 12289
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       mode,
  input  logic [$clog2(LOG_N+1)-1:0] num_stages,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done
);
  localparam int N      = 1 << LOG_N;
  localparam int HALF   = N / 2;
  localparam int SW     = $clog2(LOG_N + 1);
  localparam int TW_MAX = LOG_N * HALF;
  localparam int TWW    = $clog2(TW_MAX + 1);
  localparam int CW     = $clog2(N + TW_MAX + 1);
  localparam logic [WIDTH-1:0]   QV = WIDTH'(Q);
  localparam logic [2*WIDTH-1:0] QW = (2*WIDTH)'(Q);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic [SW-1:0]     stages_q, stages_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     s_q, s_d;
  logic [LOG_N-1:0]  k_q, k_d;
  logic              done_q, done_d;

  logic [WIDTH-1:0]  coef_q [N];
  logic [WIDTH-1:0]  twid_q [TW_MAX];

  logic [LOG_N-1:0]   lo_mask, a_idx, b_idx;
  logic [TWW-1:0]     tw_idx;
  logic [WIDTH-1:0]   x, y, w, wy, opnd, sum_r, dif_r, res_a, res_b, in_red;
  logic [2*WIDTH-1:0] prod_in, prod_out;
  logic [CW-1:0]      load_total;

  // Operands are always in [0, Q-1], so one conditional subtract reduces a sum.
  function automatic logic [WIDTH-1:0] cond_sub(input logic [WIDTH-1:0] v);
    return (v >= QV) ? v - QV : v;
  endfunction

  always_comb begin
    lo_mask  = (LOG_N'(1) << s_q) - LOG_N'(1);
    a_idx    = ((k_q >> s_q) << (s_q + SW'(1))) | (k_q & lo_mask);
    b_idx    = a_idx | (LOG_N'(1) << s_q);
    tw_idx   = TWW'(s_q) * TWW'(HALF) + TWW'(k_q);
    x        = coef_q[a_idx];
    y        = coef_q[b_idx];
    w        = twid_q[tw_idx];
    prod_in  = {{WIDTH{1'b0}}, w} * {{WIDTH{1'b0}}, y};
    wy       = WIDTH'(prod_in % QW);
    // NTT twiddles y before the add/sub; INTT twiddles the difference afterwards.
    opnd     = mode_q ? wy : y;
    sum_r    = cond_sub(x + opnd);
    dif_r    = cond_sub(x + QV - opnd);
    prod_out = {{WIDTH{1'b0}}, dif_r} * {{WIDTH{1'b0}}, w};
    res_a    = sum_r;
    res_b    = mode_q ? dif_r : WIDTH'(prod_out % QW);
    in_red   = in_data % QV;
  end

  assign load_total = CW'(N) + CW'(stages_q) * CW'(HALF);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    stages_d  = stages_q;
    cnt_d     = cnt_q;
    s_d       = s_q;
    k_d       = k_q;
    done_d    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = coef_q[cnt_q[LOG_N-1:0]];
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d   = mode;
          stages_d = (num_stages == '0 || num_stages > SW'(LOG_N)) ? SW'(LOG_N) : num_stages;
          cnt_d    = '0;
          s_d      = '0;
          k_d      = '0;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (cnt_q == load_total - CW'(1)) begin
            cnt_d   = '0;
            state_d = S_COMPUTE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_COMPUTE: begin
        if (k_q == LOG_N'(HALF - 1)) begin
          k_d = '0;
          if (s_q == stages_q - SW'(1)) begin
            s_d     = '0;
            state_d = S_DRAIN;
          end else begin
            s_d = s_q + SW'(1);
          end
        end else begin
          k_d = k_q + LOG_N'(1);
        end
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        out_last  = (cnt_q == CW'(N - 1));
        if (out_ready) begin
          if (out_last) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      stages_q <= '0;
      cnt_q    <= '0;
      s_q      <= '0;
      k_q      <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      stages_q <= stages_d;
      cnt_q    <= cnt_d;
      s_q      <= s_d;
      k_q      <= k_d;
      done_q   <= done_d;
    end
  end

  // Register file is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (state_q == S_LOAD && in_valid) begin
      if (cnt_q < CW'(N)) coef_q[cnt_q[LOG_N-1:0]] <= in_red;
      else                twid_q[TWW'(cnt_q - CW'(N))] <= in_red;
    end else if (state_q == S_COMPUTE) begin
      coef_q[a_idx] <= res_a;
      coef_q[b_idx] <= res_b;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_ntt_stream_engine.sv
// Directed and randomized jobs for ntt_stream_engine (Q=17, N=8), checked against
// a block/span formulation of the transform computed with plain integer arithmetic.
module tb_ntt_stream_engine;
  localparam int WIDTH = 18;
  localparam int LOG_N = 3;
  localparam int Q     = 17;
  localparam int N     = 8;
  localparam int SW    = 2;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic             mode = 1'b0;
  logic [SW-1:0]    num_stages = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  int c_seq[8], c_delta[8], c_red[8], c_rnd[8];
  int t_one[12], t_two[12], t_rnd[12];
  int outs[8];
  int exp1[8], exp2[8];
  int done_seen;

  always #5 clock = ~clock;

  ntt_stream_engine #(.WIDTH(WIDTH), .LOG_N(LOG_N), .Q(Q)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .mode(mode),
    .num_stages(num_stages), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Stages processed as blocks of width 2*span; butterfly number k runs across blocks.
  task automatic model(input bit m, input int S, input int c_in[8], input int t_in[12],
                       output int c[8]);
    int t[12];
    int span, k, a, b, x, y, w, p;
    for (int i = 0; i < 8; i++) c[i] = c_in[i] % Q;
    for (int i = 0; i < 12; i++) t[i] = t_in[i] % Q;
    for (int s = 0; s < S; s++) begin
      span = 1 << s;
      for (int base = 0; base < N; base += 2 * span) begin
        for (int j = 0; j < span; j++) begin
          a = base + j;
          b = a + span;
          k = base / 2 + j;
          w = t[s * (N / 2) + k];
          x = c[a];
          y = c[b];
          if (m) begin
            p = (w * y) % Q;
            c[a] = (x + p) % Q;
            c[b] = (x - p + Q) % Q;
          end else begin
            c[a] = (x + y) % Q;
            c[b] = ((x - y + Q) * w) % Q;
          end
        end
      end
    end
  endtask

  // Called at a falling edge with the engine idle (or showing its done pulse).
  task automatic do_job(input string nm, input bit m, input int ns, input int c_in[8],
                        input int t_in[12], input bit gaps, input bit bp, output int res[8]);
    int S, total, i, n, j, p, guard;
    int words[20];
    int exp[8];
    logic [WIDTH-1:0] held;
    bit stalled, hs;
    S = (ns == 0 || ns > LOG_N) ? LOG_N : ns;
    total = N + S * (N / 2);
    for (int q = 0; q < 8; q++) words[q] = c_in[q];
    for (int q = 0; q < 12; q++) words[8 + q] = t_in[q];
    for (int q = 0; q < 8; q++) res[q] = -1;
    start = 1'b1;
    mode = m;
    num_stages = SW'(ns);
    @(negedge clock);
    start = 1'b0;
    chk({nm, ":in_ready_load"}, 32'(in_ready), 1);
    chk({nm, ":busy_load"}, 32'(busy), 1);
    chk({nm, ":done_single"}, 32'(done), 0);
    i = 0;
    guard = 0;
    while (i < total && guard < 1000) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data = WIDTH'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data = WIDTH'(words[i]);
      end
      hs = in_valid && in_ready;
      @(negedge clock);
      guard++;
      if (hs) i++;
    end
    chk({nm, ":load_count"}, 32'(i), 32'(total));
    chk({nm, ":in_ready_compute"}, 32'(in_ready), 0);
    // Junk on the input stream during compute must be ignored.
    in_valid = 1'b1;
    in_data = WIDTH'($urandom);
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clock);
      n++;
    end
    in_valid = 1'b0;
    chk({nm, ":latency"}, 32'(n), 32'(S * (N / 2)));
    j = 0;
    p = 0;
    guard = 0;
    stalled = 1'b0;
    held = '0;
    while (j < 8 && guard < 500) begin
      chk({nm, ":out_valid"}, 32'(out_valid), 1);
      chk({nm, ":out_last"}, 32'(out_last), 32'(j == 7));
      if (stalled) chk({nm, ":hold"}, 32'(out_data), 32'(held));
      out_ready = bp ? ((p % 4 == 0) || (p % 4 == 3)) : 1'b1;
      p++;
      if (out_ready && out_valid) begin
        res[j] = int'(out_data);
        j++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held = out_data;
      end
      @(negedge clock);
      guard++;
    end
    out_ready = 1'b0;
    chk({nm, ":drain_count"}, 32'(j), 8);
    chk({nm, ":done"}, 32'(done), 1);
    chk({nm, ":busy_end"}, 32'(busy), 0);
    chk({nm, ":out_valid_end"}, 32'(out_valid), 0);
    model(m, S, c_in, t_in, exp);
    for (int q = 0; q < 8; q++) chk($sformatf("%s:model[%0d]", nm, q), 32'(res[q]), 32'(exp[q]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int q = 0; q < 8; q++) begin
      c_seq[q] = q + 1;
      c_delta[q] = (q == 0) ? 1 : 0;
      c_red[q] = (q == 0) ? 20 : 0;
    end
    for (int q = 0; q < 12; q++) begin
      t_one[q] = 1;
      t_two[q] = 2;
    end
    exp1 = '{3, 16, 7, 16, 11, 16, 15, 16};
    exp2 = '{3, 15, 7, 15, 11, 15, 15, 15};

    #1;
    chk("rst:in_ready", 32'(in_ready), 0);
    chk("rst:out_valid", 32'(out_valid), 0);
    chk("rst:out_last", 32'(out_last), 0);
    chk("rst:busy", 32'(busy), 0);
    chk("rst:done", 32'(done), 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    do_job("ntt_s1", 1'b1, 1, c_seq, t_one, 1'b0, 1'b0, outs);
    for (int q = 0; q < 8; q++) chk($sformatf("ntt_s1:const[%0d]", q), 32'(outs[q]), 32'(exp1[q]));

    do_job("intt_s1", 1'b0, 1, c_seq, t_two, 1'b0, 1'b0, outs);
    for (int q = 0; q < 8; q++) chk($sformatf("intt_s1:const[%0d]", q), 32'(outs[q]), 32'(exp2[q]));

    do_job("ntt_clamp", 1'b1, 0, c_delta, t_one, 1'b0, 1'b0, outs);
    for (int q = 0; q < 8; q++) chk($sformatf("ntt_clamp:const[%0d]", q), 32'(outs[q]), 1);

    do_job("reduce", 1'b1, 1, c_red, t_one, 1'b0, 1'b0, outs);
    chk("reduce:out0", 32'(outs[0]), 3);
    chk("reduce:out1", 32'(outs[1]), 3);

    do_job("backpressure", 1'b1, 1, c_seq, t_one, 1'b1, 1'b1, outs);
    for (int q = 0; q < 8; q++) chk($sformatf("backpressure:const[%0d]", q), 32'(outs[q]), 32'(exp1[q]));

    for (int r = 0; r < 5; r++) begin
      for (int q = 0; q < 8; q++) c_rnd[q] = int'($urandom_range(0, 262143));
      for (int q = 0; q < 12; q++) t_rnd[q] = int'($urandom_range(0, 262143));
      do_job($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
             c_rnd, t_rnd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), outs);
    end

    // Abort mid-compute with reset.
    @(negedge clock);
    start = 1'b1;
    mode = 1'b1;
    num_stages = 2'd3;
    @(negedge clock);
    start = 1'b0;
    for (int q = 0; q < 20; q++) begin
      in_valid = 1'b1;
      in_data = WIDTH'($urandom_range(0, 100));
      @(negedge clock);
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clock);
    chk("abort:busy_before", 32'(busy), 1);
    reset_n = 1'b0;
    #1;
    chk("abort:busy", 32'(busy), 0);
    chk("abort:out_valid", 32'(out_valid), 0);
    chk("abort:in_ready", 32'(in_ready), 0);
    @(negedge clock);
    reset_n = 1'b1;
    done_seen = 0;
    for (int q = 0; q < 30; q++) begin
      @(negedge clock);
      if (done || out_valid) done_seen++;
    end
    chk("abort:no_done", 32'(done_seen), 0);

    for (int q = 0; q < 8; q++) c_rnd[q] = int'($urandom_range(0, 262143));
    for (int q = 0; q < 12; q++) t_rnd[q] = int'($urandom_range(0, 262143));
    do_job("post_reset", 1'b0, 3, c_rnd, t_rnd, 1'b1, 1'b0, outs);
    @(negedge clock);
    chk("final:done_low", 32'(done), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ntt_stream_engine.md
Name: ntt_stream_engine

Overview:
Parametrised, iterative successor to the fixed 8-point three-stage radix-2 core. It holds N = 2^LOG_N coefficients in a register file and runs one modular butterfly per cycle over a selectable number of stages. NTT uses Cooley-Tukey butterflies and INTT uses Gentleman-Sande butterflies. Coefficients and twiddles arrive on one valid/ready input stream; results leave on a valid/ready output stream with backpressure. It replaces the fixed serial/parallel converters and the radix output mux with a single load/compute/drain controller.

Parameters:
WIDTH, 18, data/twiddle word width in bits
LOG_N, 3, log2 of transform size N (N = 2^LOG_N points)
Q, 12289, prime modulus; must satisfy Q < 2^(WIDTH-1)

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  begin a job; sampled only in IDLE
mode  input  1  1 = NTT (Cooley-Tukey), 0 = INTT (Gentleman-Sande); latched at start
num_stages  input  $clog2(LOG_N+1)  stages S to run; latched at start; 0 or >LOG_N clamps to LOG_N
in_valid  input  1  input word valid
in_ready  output  1  engine accepts an input word
in_data  input  WIDTH  coefficient or twiddle word
out_valid  output  1  output word valid
out_ready  input  1  downstream accepts an output word
out_data  output  WIDTH  result coefficient
out_last  output  1  high with the final (index N-1) output word
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after the last output handshake

Behaviour:
- Reset (async, reset_n=0): state=IDLE. in_ready=0, out_valid=0, out_last=0, busy=0, done=0, all counters=0. Register-file contents are not cleared.
- States: IDLE -> LOAD -> COMPUTE -> DRAIN -> IDLE.
- IDLE: start=1 at edge t latches mode and S (after clamping); LOAD from t+1. start in any other state is ignored.
- LOAD: in_ready=1. Handshake = in_valid & in_ready.
  - First N accepted words go to coef[0..N-1] in order.
  - The next S*N/2 words go to twid[0..S*N/2-1].
  - Every word is stored reduced: in_data % Q.
  - The cycle after the last accepted word: COMPUTE, in_ready=0.
- COMPUTE: one butterfly per cycle, S*N/2 cycles total, with stage s=0..S-1 and butterfly k=0..N/2-1.
  - Pair indices: a = ((k>>s)<<(s+1)) | (k & (2^s-1)), b = a + 2^s.
  - Twiddle: w = twid[s*N/2 + k].
  - NTT: coef[a] <= (x + w*y) mod Q, coef[b] <= (x - w*y) mod Q.
  - INTT: coef[a] <= (x + y) mod Q, coef[b] <= ((x - y) * w) mod Q.
  - x = coef[a] and y = coef[b], read combinationally. The product is 2*WIDTH bits wide. Subtraction adds Q before reduction so the result is never negative. Results are always in [0, Q-1].
  - Writeback lands on the same edge. The next butterfly sees the updated values.
  - The edge after the final butterfly enters DRAIN.
- DRAIN: out_valid=1, out_data=coef[idx], idx from 0 to N-1 in natural order, out_last=(idx==N-1).
  - idx advances only on out_valid & out_ready.
  - out_data is held stable while out_ready=0.
  - The handshake with out_last enters IDLE, and done=1 for the following cycle.
- Latency: S*N/2 cycles from the final load handshake to out_valid=1 (the COMPUTE duration). A full job with no stalls takes 1 + N + S*N/2 + S*N/2 + N cycles from start to the last handshake.
- Boundary conditions:
  - in_valid outside LOAD is ignored.
  - Input stalls (in_valid=0) freeze the load counters.
  - Reset mid-job aborts immediately to IDLE, and no done pulse is issued.
  - start together with the done pulse is accepted, because the engine is already in IDLE.

Test Plan:
- Q=17, NTT, num_stages=1, coefficients 1..8, four twiddles =1 -> outputs 3,16,7,16,11,16,15,16; out_last on the 8th word; done pulses once.
- Q=17, INTT, num_stages=1, coefficients 1..8, twiddles =2 -> outputs 3,15,7,15,11,15,15,15.
- Q=17, NTT, num_stages=0 (clamps to 3), coefficients 1,0,0,0,0,0,0,0, twelve twiddles =1 -> all eight outputs =1; first out_valid exactly 12 cycles after the last load handshake.
- Input reduction: Q=17, num_stages=1, coefficients 20,0,... with twiddles =1 -> out_data[0]=3, out_data[1]=3.
- Backpressure: repeat scenario 1 with out_ready toggling 1,0,0,1,... and random in_valid gaps -> identical output sequence, out_data stable during stalls, no word dropped or duplicated.
- Reset: assert reset_n=0 mid-COMPUTE -> busy=0, out_valid=0, in_ready=0 at once. A new job after release produces correct results, and no done pulse comes from the aborted job.
